// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared constants and state encoding for the multiply/divide unit
// Contents:
//   M_MUL..M_REMU : RV32M funct3 operation codes
//   state_t       : control FSM states (IDLE, MUL, DIV, DONE)
package mdu_pkg;

    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mdu_divstep.sv
// rtl/mdu_divstep.sv - one combinational restoring-division step
// Ports:
//   rem      : partial remainder before this step (always < divisor)
//   msb      : next dividend bit shifted into the remainder
//   divisor  : divisor magnitude
//   rem_next : partial remainder after the trial subtract/restore
//   q_bit    : quotient bit produced by this step
module mdu_divstep #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic            msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);

    // The shifted remainder needs one extra bit; the restored or reduced
    // value is always below the divisor, so it fits back into XLEN bits.
    logic [XLEN:0] partial;

    always_comb begin
        partial  = {rem, msb};
        q_bit    = (partial >= {1'b0, divisor});
        rem_next = q_bit ? XLEN'(partial - {1'b0, divisor}) : partial[XLEN-1:0];
    end

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - iterative RV32M multiply/divide unit with request/response handshake
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   req_valid/req_ready   : request handshake; funct3, rs1, rs2 captured on accept
//   resp_valid/resp_ready : response handshake; result held until accepted
//   result                : operation result, zero whenever resp_valid is low
//   busy                  : high in any state other than IDLE
module mdu
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int         W2   = 2 * XLEN;
    localparam logic [5:0] LAST = 6'(XLEN - 1);

    state_t            state, state_nx;
    logic [2:0]        op;
    logic [5:0]        cnt;
    logic [W2-1:0]     acc;     // MUL: {partial high, multiplier}; DIV: {remainder, dividend/quotient}
    logic [XLEN-1:0]   opnd;    // multiplicand or divisor magnitude
    logic              neg_q;   // negate product / quotient at the end
    logic              neg_r;   // negate remainder at the end

    // Request decode, used only on the accept edge.
    logic            a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        a_signed = (funct3 == M_MULH) || (funct3 == M_MULHSU) ||
                   (funct3 == M_DIV)  || (funct3 == M_REM);
        b_signed = (funct3 == M_MULH) || (funct3 == M_DIV) || (funct3 == M_REM);
        a_neg    = a_signed && rs1[XLEN-1];
        b_neg    = b_signed && rs2[XLEN-1];
        a_mag    = a_neg ? -rs1 : rs1;
        b_mag    = b_neg ? -rs2 : rs2;
        div_zero = funct3[2] && (rs2 == '0);
        div_ovf  = ((funct3 == M_DIV) || (funct3 == M_REM)) &&
                   (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    end

    // Shift-add multiply step: add multiplicand when the multiplier LSB is set,
    // then shift the whole accumulator right, carry included.
    logic [XLEN:0]   mul_sum;
    logic [W2-1:0]   mul_next;
    logic [XLEN-1:0] div_rem;
    logic            div_q;
    logic [W2-1:0]   div_next;

    always_comb begin
        mul_sum  = {1'b0, acc[W2-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
        div_next = {div_rem, acc[XLEN-2:0], div_q};
    end

    mdu_divstep #(.XLEN(XLEN)) u_divstep (
        .rem      (acc[W2-1:XLEN]),
        .msb      (acc[XLEN-1]),
        .divisor  (opnd),
        .rem_next (div_rem),
        .q_bit    (div_q)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (req_valid) begin
                if (!funct3[2])             state_nx = S_MUL;
                else if (div_zero || div_ovf) state_nx = S_DONE;
                else                        state_nx = S_DIV;
            end
            S_MUL, S_DIV: if (cnt == LAST) state_nx = S_DONE;
            S_DONE: if (resp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            op    <= '0;
            cnt   <= '0;
            acc   <= '0;
            opnd  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: if (req_valid) begin
                    op    <= funct3;
                    cnt   <= '0;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    // Special divide cases preload the final quotient/remainder
                    // so the common output path produces the architected value.
                    if (div_zero) begin
                        acc   <= {rs1, {XLEN{1'b1}}};
                        opnd  <= '0;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end else if (div_ovf) begin
                        acc   <= {{XLEN{1'b0}}, rs1};
                        opnd  <= '0;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end else if (funct3[2]) begin
                        acc  <= {{XLEN{1'b0}}, a_mag};
                        opnd <= b_mag;
                    end else begin
                        acc  <= {{XLEN{1'b0}}, b_mag};
                        opnd <= a_mag;
                    end
                end
                S_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 6'd1;
                end
                S_DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 6'd1;
                end
                S_DONE: if (resp_ready) begin
                    acc <= '0;
                    cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // Sign correction applied to the magnitude result held in DONE.
    logic [W2-1:0]   prod;
    logic [XLEN-1:0] quo, rem_v, sel;

    always_comb begin
        prod  = neg_q ? -acc : acc;
        quo   = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_v = neg_r ? -acc[W2-1:XLEN] : acc[W2-1:XLEN];
        case (op)
            M_MUL:                     sel = prod[XLEN-1:0];
            M_MULH, M_MULHSU, M_MULHU: sel = prod[W2-1:XLEN];
            M_DIV, M_DIVU:             sel = quo;
            default:                   sel = rem_v;
        endcase
    end

    assign req_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign resp_valid = (state == S_DONE);
    assign result     = resp_valid ? sel : '0;

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 is required to be supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 rs1  input  XLEN  operand A (dividend/multiplicand).
REQ-008 rs2  input  XLEN  operand B (divisor/multiplier).
REQ-009 resp_valid  output  1  result present.
REQ-010 resp_ready  input  1  consumer accepts result.
REQ-011 result  output  XLEN  operation result.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The unit SHALL have states IDLE, MUL, DIV and DONE.
REQ-014 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-015 On accept, funct3, rs1 and rs2 SHALL be captured; later changes on these inputs SHALL have no effect on the operation in flight.
REQ-016 On accept with funct3[2]=0: IDLE->MUL; 32 radix-2 shift-add iterations (one per cycle); then MUL->DONE.
REQ-017 On accept with funct3[2]=1, normal operands: IDLE->DIV; 32 restoring-division iterations; then DIV->DONE.
REQ-018 Normal-case latency SHALL be fixed: resp_valid first high 33 cycles after the accept edge, independent of operand values.
REQ-019 Signed ops SHALL use magnitudes internally, with sign correction applied at the end of the operation: MULH signed x signed, MULHSU signed rs1 x unsigned rs2, MULHU unsigned x unsigned.
REQ-020 MUL SHALL return product bits [31:0]; MULH/MULHSU/MULHU SHALL return bits [63:32] of the 64-bit product.
REQ-021 DIV/REM SHALL truncate toward zero; remainder sign SHALL equal dividend sign.
REQ-022 Divide by zero: DIV/DIVU SHALL return 0xFFFFFFFF, REM/REMU SHALL return rs1; the unit SHALL go IDLE->DONE directly (resp_valid 1 cycle after accept).
REQ-023 Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV SHALL return 0x80000000 and REM SHALL return 0, via IDLE->DONE in 1 cycle.
REQ-024 In DONE, resp_valid SHALL be 1 and result SHALL stay stable until resp_ready=1; the handshake edge SHALL move DONE->IDLE.
REQ-025 There SHALL be no accept in the cycle of the response handshake (req_ready=0 in DONE); the next request is accepted no earlier than the cycle after.
REQ-026 result SHALL be 0 whenever resp_valid=0.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force IDLE, resp_valid=0, result=0, busy=0 and clear all iteration counters and datapath registers.
REQ-028 A reset during MUL, DIV or DONE SHALL abandon the operation with no response emitted afterwards; req_ready=1 on the first edge with rst_n=1.
REQ-029 Reset SHALL take priority over any handshake sampled at the same edge.

Structure
REQ-030 The M-extension funct3 codes (`M_MUL ... `M_REMU) and the MDU state encodings SHALL be added to defs.v as macros.
REQ-031 A 6-bit iteration counter and one 64-bit shared accumulator/remainder register SHALL be used; there is no combinational 32x32 multiplier.
REQ-032 One sub-module, mdu_divstep, SHALL be the natural split: a combinational restoring-division step (trial subtract, quotient bit, next remainder).

Verification
REQ-033 MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB, resp_valid exactly 33 cycles after accept.
REQ-034 rs1=rs2=0xFFFFFFFF: MULHU -> 0xFFFFFFFE, MULH -> 0x00000000, MULHSU -> 0xFFFFFFFF.
REQ-035 DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-036 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; each with resp_valid 1 cycle after accept.
REQ-037 Hold resp_ready=0 for 10 cycles in DONE -> result stable, req_ready=0, busy=1; raise resp_ready -> req_ready=1 the following cycle.
REQ-038 Pull rst_n low on the 10th iteration of a DIV -> next edge IDLE, resp_valid=0 and no response appears; a fresh MUL 3x4 then returns 12.
